// File: rtl/seven_seg_arbiter.sv
// Round-robin arbiter that time-shares the 32-bit seven-segment display word
// between NUM_REQ requesters, with a minimum hold time per grant.
module seven_seg_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 100_000_000,
    parameter logic [31:0] IDLE_VAL    = 32'h0000_0000
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [NUM_REQ-1:0]      req_in,
    input  logic [32*NUM_REQ-1:0]   val_in,
    output logic [31:0]             val_out,
    output logic [NUM_REQ-1:0]      grant_out,
    output logic [2:0]              owner_out,
    output logic                    busy_out,
    output logic                    hold_done_out
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
    localparam logic [2:0] LAST_RST = 3'(NUM_REQ - 1);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t               state_q, state_d;
    logic [2:0]           owner_q, owner_d;
    logic [2:0]           last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [31:0]          val_q, val_d;
    logic                 busy_q, busy_d;
    logic                 hold_done_q, hold_done_d;

    logic [NUM_REQ-1:0]   others_c;
    logic                 owner_req_c;
    logic                 hold_done_c;

    // First set bit of mask in search order starting at last+1 (wrapping).
    function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                           input logic [2:0] last);
        int best;
        int d;
        logic [2:0] pick;
        best = int'(NUM_REQ);
        pick = 3'd0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            d = j - int'(last) - 1;
            if (d < 0) d = d + int'(NUM_REQ);
            if (mask[j] && d < best) begin
                best = d;
                pick = 3'(j);
            end
        end
        return pick;
    endfunction

    assign others_c    = req_in & ~grant_q;
    assign owner_req_c = |(req_in & grant_q);
    assign hold_done_c = (cnt_q == HOLD_MAX);

    // Next-state: arbitration, hold counter and registered output values.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        grant_d     = '0;
        val_d       = IDLE_VAL;
        busy_d      = 1'b0;
        hold_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req_in) begin
                    state_d = S_OWN;
                    owner_d = rr_pick(req_in, last_q);
                    last_d  = owner_d;
                    cnt_d   = '0;
                end
            end
            S_OWN: begin
                if (!owner_req_c) begin
                    // Releasing owner's req is already low, so it is excluded.
                    if (|req_in) begin
                        owner_d = rr_pick(req_in, last_q);
                        last_d  = owner_d;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        owner_d = 3'd0;
                        cnt_d   = '0;
                    end
                end else if (hold_done_c) begin
                    if (|others_c) begin
                        owner_d = rr_pick(others_c, last_q);
                        last_d  = owner_d;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = 3'd0;
                cnt_d   = '0;
            end
        endcase

        if (state_d == S_OWN) begin
            busy_d      = 1'b1;
            hold_done_d = (cnt_d == HOLD_MAX);
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (owner_d == 3'(i)) begin
                    grant_d[i] = 1'b1;
                    val_d      = val_in[32*i +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            owner_q     <= 3'd0;
            last_q      <= LAST_RST;
            cnt_q       <= '0;
            grant_q     <= '0;
            val_q       <= IDLE_VAL;
            busy_q      <= 1'b0;
            hold_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            val_q       <= val_d;
            busy_q      <= busy_d;
            hold_done_q <= hold_done_d;
        end
    end

    assign val_out       = val_q;
    assign grant_out     = grant_q;
    assign owner_out     = owner_q;
    assign busy_out      = busy_q;
    assign hold_done_out = hold_done_q;

endmodule

// File: tb/tb_seven_seg_arbiter.sv
// Directed testbench for seven_seg_arbiter (NUM_REQ=4, HOLD_CYCLES=8).
module tb_seven_seg_arbiter;

    localparam logic [31:0] IDLE = 32'hDEAD_0000;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic [3:0]   req_in;
    logic [31:0]  v0, v1, v2, v3;
    logic [127:0] val_in;
    logic [31:0]  val_out;
    logic [3:0]   grant_out;
    logic [2:0]   owner_out;
    logic         busy_out;
    logic         hold_done_out;

    int checks = 0;
    int errors = 0;

    assign val_in = {v3, v2, v1, v0};

    always #5 clk_in = ~clk_in;

    seven_seg_arbiter #(
        .NUM_REQ(4),
        .HOLD_CYCLES(8),
        .IDLE_VAL(IDLE)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .req_in(req_in),
        .val_in(val_in),
        .val_out(val_out),
        .grant_out(grant_out),
        .owner_out(owner_out),
        .busy_out(busy_out),
        .hold_done_out(hold_done_out)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        req_in = 4'b0000;
        v0 = 32'h1111_1111; v1 = 32'h3333_3333; v2 = 32'h2222_2222; v3 = 32'h4444_4444;
        tick(2);
        rst_n_in = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (val_out !== IDLE || grant_out !== 4'b0000 || busy_out !== 1'b0
                || owner_out !== 3'd0 || hold_done_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d val=%h grant=%b busy=%b owner=%0d hd=%b (need %h 0000 0 0 0)",
                         c, val_out, grant_out, busy_out, owner_out, hold_done_out, IDLE);
            end
            tick(1);
        end
    endtask

    task automatic test_rotate();
        req_in = 4'b0101;
        tick(1);
        checks++;
        if (grant_out !== 4'b0001 || val_out !== 32'h1111_1111 || busy_out !== 1'b1
            || hold_done_out !== 1'b0) begin
            errors++;
            $display("FAIL rot_first grant=%b val=%h busy=%b hd=%b (need 0001 11111111 1 0)",
                     grant_out, val_out, busy_out, hold_done_out);
        end
        // live tracking with one cycle latency
        v0 = 32'h1111_ABCD;
        checks++;
        if (val_out !== 32'h1111_1111) begin
            errors++;
            $display("FAIL rot_val_latency val=%h need 11111111", val_out);
        end
        tick(1);
        checks++;
        if (val_out !== 32'h1111_ABCD) begin
            errors++;
            $display("FAIL rot_val_track val=%h need 1111abcd", val_out);
        end
        tick(6);
        checks++;
        if (grant_out !== 4'b0001 || hold_done_out !== 1'b0) begin
            errors++;
            $display("FAIL rot_cnt7 grant=%b hd=%b (need 0001 0)", grant_out, hold_done_out);
        end
        tick(1);
        checks++;
        if (grant_out !== 4'b0001 || hold_done_out !== 1'b1) begin
            errors++;
            $display("FAIL rot_cnt8 grant=%b hd=%b (need 0001 1)", grant_out, hold_done_out);
        end
        tick(1);
        checks++;
        if (grant_out !== 4'b0100 || val_out !== 32'h2222_2222 || owner_out !== 3'd2
            || hold_done_out !== 1'b0) begin
            errors++;
            $display("FAIL rot_to2 grant=%b val=%h owner=%0d hd=%b (need 0100 22222222 2 0)",
                     grant_out, val_out, owner_out, hold_done_out);
        end
        tick(8);
        checks++;
        if (grant_out !== 4'b0100 || hold_done_out !== 1'b1) begin
            errors++;
            $display("FAIL rot_hold2 grant=%b hd=%b (need 0100 1)", grant_out, hold_done_out);
        end
        tick(1);
        checks++;
        if (grant_out !== 4'b0001 || val_out !== 32'h1111_ABCD || owner_out !== 3'd0) begin
            errors++;
            $display("FAIL rot_back0 grant=%b val=%h owner=%0d (need 0001 1111abcd 0)",
                     grant_out, val_out, owner_out);
        end
        req_in = 4'b0000;
        tick(1);
        checks++;
        if (grant_out !== 4'b0000 || busy_out !== 1'b0 || val_out !== IDLE) begin
            errors++;
            $display("FAIL rot_idle grant=%b busy=%b val=%h (need 0000 0 %h)",
                     grant_out, busy_out, val_out, IDLE);
        end
    endtask

    task automatic test_hold_alone();
        req_in = 4'b0010;
        tick(1);
        checks++;
        if (grant_out !== 4'b0010 || owner_out !== 3'd1 || val_out !== 32'h3333_3333) begin
            errors++;
            $display("FAIL alone_grant grant=%b owner=%0d val=%h (need 0010 1 33333333)",
                     grant_out, owner_out, val_out);
        end
        tick(28);
        checks++;
        if (grant_out !== 4'b0010 || hold_done_out !== 1'b1) begin
            errors++;
            $display("FAIL alone_hold grant=%b hd=%b (need 0010 1)", grant_out, hold_done_out);
        end
        req_in = 4'b1010;
        tick(1);
        checks++;
        if (grant_out !== 4'b1000 || owner_out !== 3'd3 || val_out !== 32'h4444_4444
            || hold_done_out !== 1'b0) begin
            errors++;
            $display("FAIL alone_to3 grant=%b owner=%0d val=%h hd=%b (need 1000 3 44444444 0)",
                     grant_out, owner_out, val_out, hold_done_out);
        end
        req_in = 4'b0000;
        tick(1);
    endtask

    task automatic test_preempt_guard();
        req_in = 4'b0001;
        tick(1);
        checks++;
        if (grant_out !== 4'b0001) begin
            errors++;
            $display("FAIL guard_grant grant=%b need 0001", grant_out);
        end
        tick(1);
        req_in = 4'b0011;
        for (int c = 0; c < 7; c++) begin
            tick(1);
            checks++;
            if (grant_out !== 4'b0001) begin
                errors++;
                $display("FAIL guard_hold step=%0d grant=%b need 0001", c, grant_out);
            end
        end
        tick(1);
        checks++;
        if (grant_out !== 4'b0010 || owner_out !== 3'd1) begin
            errors++;
            $display("FAIL guard_move grant=%b owner=%0d (need 0010 1)", grant_out, owner_out);
        end
        req_in = 4'b0000;
        tick(1);
    endtask

    task automatic test_early_release();
        req_in = 4'b0100;
        tick(1);
        checks++;
        if (grant_out !== 4'b0100) begin
            errors++;
            $display("FAIL early_grant grant=%b need 0100", grant_out);
        end
        tick(2);
        req_in = 4'b1001;
        tick(1);
        checks++;
        if (grant_out !== 4'b1000 || busy_out !== 1'b1 || owner_out !== 3'd3
            || val_out !== 32'h4444_4444) begin
            errors++;
            $display("FAIL early_next grant=%b busy=%b owner=%0d val=%h (need 1000 1 3 44444444)",
                     grant_out, busy_out, owner_out, val_out);
        end
        req_in = 4'b0000;
        tick(1);
    endtask

    task automatic test_reset_mid();
        req_in = 4'b0010;
        tick(3);
        checks++;
        if (grant_out !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_own grant=%b need 0010", grant_out);
        end
        rst_n_in = 1'b0;
        req_in = 4'b1111;
        tick(1);
        checks++;
        if (grant_out !== 4'b0000 || val_out !== IDLE || busy_out !== 1'b0
            || owner_out !== 3'd0 || hold_done_out !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear grant=%b val=%h busy=%b owner=%0d hd=%b (need 0000 %h 0 0 0)",
                     grant_out, val_out, busy_out, owner_out, hold_done_out, IDLE);
        end
        rst_n_in = 1'b1;
        tick(1);
        checks++;
        if (grant_out !== 4'b0001 || owner_out !== 3'd0 || val_out !== 32'h1111_ABCD) begin
            errors++;
            $display("FAIL rstmid_first grant=%b owner=%0d val=%h (need 0001 0 1111abcd)",
                     grant_out, owner_out, val_out);
        end
    endtask

    initial begin
        rst_n_in = 1'b0;
        req_in = 4'b0000;
        v0 = '0; v1 = '0; v2 = '0; v3 = '0;
        test_reset();
        test_rotate();
        test_hold_alone();
        test_preempt_guard();
        test_early_release();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_arbiter.md
# seven_seg_arbiter

Time-shares the single 8-digit seven-segment display between NUM_REQ requesters, such as debug counters, an FSM state readout and error codes. It owns the 32-bit display word that feeds `seven_seg_controller.val_in` and grants ownership round-robin. Each grant is protected by a minimum hold time so a value stays readable before another requester takes over. When nobody requests, it drives a fixed idle word.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- HOLD_CYCLES, 100_000_000: minimum ownership time in clk_in cycles; must be ≥1. Counter width is $clog2(HOLD_CYCLES+1).
- IDLE_VAL, 32'h0000_0000: display word while no requester owns the display.
- clk_in  input  1: single clock, rising edge.
- rst_n_in  input  1: reset, synchronous, active-low.
- req_in  input  NUM_REQ: level request per requester; held high while the requester wants the display.
- val_in  input  32*NUM_REQ: requester i drives its display word on bits [32*i+31:32*i].
- val_out  output  32: display word to the seven-seg controller.
- grant_out  output  NUM_REQ: one-hot current owner, or all-zero when idle.
- owner_out  output  3: binary index of the current owner; 0 when idle.
- busy_out  output  1: high while some requester owns the display.
- hold_done_out  output  1: high once the current owner's hold time has elapsed.

## Operation
- States:
  - IDLE: no owner; val_out = IDLE_VAL.
  - OWN: one owner; val_out tracks that owner's val_in live.
- Round-robin pointer `last`:
  - Search order starts at (last+1) mod NUM_REQ.
  - Reset value of last = NUM_REQ-1, so index 0 wins the first arbitration.
  - last updates to the new owner on every grant.
- IDLE with any req_in bit high: grant the first requester in search order and go to OWN. The hold counter clears to 0.
- OWN, hold counter:
  - Increments each cycle and saturates at HOLD_CYCLES.
  - hold_done = (counter == HOLD_CYCLES).
- OWN, owner drops its req (any time, including before hold_done): release immediately.
  - If any other req is high, grant the next requester in search order directly, with no idle cycle between owners.
  - Otherwise go to IDLE.
- OWN, hold_done, owner still requesting:
  - If any other req is high, rotate to the next requester in search order.
  - Otherwise keep the owner, with the counter staying saturated.
- OWN, hold not done, owner still requesting: no preemption; other requests wait.
- Simultaneous owner release and new requests: treated as a release. The search excludes the releasing owner because its req is low.
- Exactly one grant bit is high in OWN; all bits are zero in IDLE.
- val_in of non-owners is ignored.
- Requests are levels, not pulses. A requester that drops req before being granted is skipped.

## Timing
- All outputs are registered.
- Reset values, applied on the clock edge with rst_n_in=0:
  - val_out = IDLE_VAL
  - grant_out = 0
  - owner_out = 0
  - busy_out = 0
  - hold_done_out = 0
  - counter = 0
  - last = NUM_REQ-1
- Grant latency: req_in sampled high at edge N gives grant_out/busy_out valid after edge N.
- val_out latency:
  - val_out reflects the new owner's val_in sampled at the same edge.
  - After that, val_out follows the owner's val_in with 1 cycle of latency.
- Counter and hold_done_out:
  - The counter is 0 in the first cycle of ownership.
  - hold_done_out rises in the cycle where the counter reaches HOLD_CYCLES, i.e. HOLD_CYCLES cycles after grant_out rose.
  - HOLD_CYCLES=1 means an owner is rotatable from its second owned cycle.
- Release latency: owner req low at edge N gives the new grant, or IDLE, after edge N.
- Reset mid-operation: all state returns to reset values at that edge; no grant persists.

## Test plan
- Reset, no requests, IDLE_VAL=32'hDEAD_0000: after reset, val_out=DEAD_0000, grant_out=0, busy_out=0 for 20 cycles.
- HOLD_CYCLES=8, req_in=4'b0101, val0=32'h1111_1111, val2=32'h2222_2222:
  - req 0 is granted 1 cycle after sampling, val_out=1111_1111.
  - After 8 cycles, grant moves to req 2 with val_out=2222_2222.
  - After another 8 cycles, grant returns to req 0.
- HOLD_CYCLES=8, owner 1 alone: grant is held indefinitely with hold_done_out=1. Raise req 3: grant_out=4'b1000 on the next cycle.
- Preemption guard: owner 0 granted, req 1 rises at cycle 2 of ownership: grant stays on 0 until the counter reaches 8, then moves to 1.
- Early release: owner 2 drops req at cycle 3 while req 0 and req 3 are high: the next cycle grants 3 (search order after 2), with no IDLE gap.
- Reset mid-OWN: rst_n_in low for 1 cycle while owner 1 holds: the next cycle shows grant_out=0 and val_out=IDLE_VAL. On release, with all reqs high, index 0 is granted first.
